fifo_arb_ctrl: RTL

FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/fifo_arb_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the arbitrated FIFO front-end: controller states and
// default sizing constants.
package fifo_ctrl_pkg;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage : fifo_ctrl_pkg

// File: rtl/rr_arbiter.sv
// Round-robin search: the first asserted request at or after last_winner+1
// (modulo NREQ) wins. Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   winner
);

  always_comb begin
    int   k;
    logic found;
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(last_winner) + 1 + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        winner = IW'(k);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/fifo_arb_ctrl.sv
// Front-end controller for an external FIFO: round-robin write arbitration,
// consumer pops with one-cycle read latency, flush draining and a shadow level.
module fifo_arb_ctrl #(
  parameter int NREQ  = fifo_ctrl_pkg::NREQ,
  parameter int DEPTH = fifo_ctrl_pkg::DEPTH,
  parameter int WIDTH = fifo_ctrl_pkg::WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       pop_req,
  output logic                       pop_valid,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       flush,
  output logic                       fifo_write_ctrl,
  output logic [WIDTH-1:0]           fifo_write_data,
  output logic                       fifo_read_ctrl,
  input  logic [WIDTH-1:0]           fifo_read_data,
  input  logic                       fifo_is_full,
  input  logic                       fifo_is_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [1:0]                 state
);

  import fifo_ctrl_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  state_e        r_state;
  logic [IW-1:0] r_last;
  logic [LW-1:0] r_level;
  logic          r_pop_valid;

  logic [NREQ-1:0] w_arb_gnt;
  logic [IW-1:0]   w_winner;
  logic            w_can_write;
  logic            w_rd;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req         (req),
    .last_winner (r_last),
    .gnt         (w_arb_gnt),
    .winner      (w_winner)
  );

  // Strobes are gated by rst so nothing reaches the FIFO in a reset cycle.
  assign w_can_write     = !rst && (r_state == RUN) && !fifo_is_full;
  assign gnt             = w_can_write ? w_arb_gnt : '0;
  assign fifo_write_ctrl = |gnt;
  assign fifo_write_data = req_data[w_winner];

  assign w_rd = !rst && !fifo_is_empty &&
                (((r_state == RUN) && pop_req) || (r_state == FLUSH));
  assign fifo_read_ctrl = w_rd;

  assign pop_valid = r_pop_valid;
  assign pop_data  = r_pop_valid ? fifo_read_data : '0;
  assign level     = r_level;
  assign state     = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= IW'(NREQ - 1);
      r_level     <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE:    if (enable) r_state <= RUN;
        RUN: begin
          if (flush)                          r_state <= FLUSH;
          else if (!enable && fifo_is_empty)  r_state <= IDLE;
        end
        FLUSH:   if (fifo_is_empty && !flush) r_state <= RUN;
        default: r_state <= IDLE;
      endcase

      if (fifo_write_ctrl) r_last <= w_winner;

      // Only consumer pops produce data; drain pops are discarded.
      r_pop_valid <= w_rd && (r_state == RUN);

      if (fifo_write_ctrl && !w_rd && (r_level != LW'(DEPTH)))
        r_level <= r_level + 1'b1;
      else if (w_rd && !fifo_write_ctrl && (r_level != '0))
        r_level <= r_level - 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_no_wr_full: assert property (@(posedge clk) disable iff (rst) !(fifo_write_ctrl && fifo_is_full));
  a_no_rd_empty: assert property (@(posedge clk) disable iff (rst) !(fifo_read_ctrl && fifo_is_empty));
  a_lvl_empty: assert property (@(posedge clk) disable iff (rst) ((level == '0) == fifo_is_empty));
  a_lvl_full: assert property (@(posedge clk) disable iff (rst) ((level == LW'(DEPTH)) == fifo_is_full));
`endif

endmodule : fifo_arb_ctrl
